// File: rtl/text_video_pkg.sv
// Shared types and cell geometry for the text-mode video pipeline.
// TEXT_NINE_DOT_EN selects 9-pixel cells instead of 8.
package text_video_pkg;
  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam int   GLYPH_W   = 8;
`ifdef TEXT_NINE_DOT_EN
  localparam int   CELL_W    = 9;
`else
  localparam int   CELL_W    = 8;
`endif
  localparam int   PIXCNT_W  = $clog2(CELL_W + 1);
endpackage

// File: rtl/text_blink_timer.sv
// Frame-counted blink phase: toggles every PERIOD frame_start pulses.
// Latency: phase changes on the clock after the wrapping frame_start; no backpressure.
module text_blink_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic phase
);
  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (frame_start) begin
      if (cnt == CW'(PERIOD - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/text_pixel_serializer.sv
// Serialises one glyph row per character cell into RGB pixels with blink/cursor overlay (TEXT_NINE_DOT_EN: 9-dot cells).
// Latency: first pixel 1 cycle after load; no backpressure, runs at the pixel clock.
module text_pixel_serializer
  import text_video_pkg::*;
#(
  parameter int CHAR_BLINK_FRAMES   = 16,
  parameter int CURSOR_BLINK_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [GLYPH_W-1:0] glyph_row,
  input  logic [23:0]        fgrgb,
  input  logic [23:0]        bgrgb,
  input  logic               blink,
  input  logic               cursor_here,
  input  logic               active,
  input  logic               frame_start,
`ifdef TEXT_NINE_DOT_EN
  input  logic               lg_dup,
`endif
  output logic [23:0]        pix_rgb,
  output logic               pix_valid,
  output logic               blink_phase
);
  logic [CELL_W-1:0]   sr, cell_bits, c_sr;
  logic [PIXCNT_W-1:0] cnt, c_cnt;
  rgb_t                fg_q, bg_q, c_fg, c_bg, pix_next;
  logic                blink_q, cursor_q, c_blink, c_cursor;
  logic                char_phase, cursor_phase;

`ifdef TEXT_NINE_DOT_EN
  // Line-graphics characters extend their rightmost column into the 9th dot.
  assign cell_bits = {glyph_row, lg_dup & glyph_row[0]};
`else
  assign cell_bits = glyph_row;
`endif

  text_blink_timer #(.PERIOD(CHAR_BLINK_FRAMES)) u_char_blink (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .phase       (char_phase)
  );

  text_blink_timer #(.PERIOD(CURSOR_BLINK_FRAMES)) u_cursor_blink (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .phase       (cursor_phase)
  );

  assign blink_phase = char_phase;

  // A load bypasses the cell registers so its first pixel leaves on the next edge.
  always_comb begin
    c_sr     = sr;
    c_cnt    = cnt;
    c_fg     = fg_q;
    c_bg     = bg_q;
    c_blink  = blink_q;
    c_cursor = cursor_q;
    if (load) begin
      c_sr     = cell_bits;
      c_cnt    = PIXCNT_W'(CELL_W);
      c_fg     = fgrgb;
      c_bg     = bgrgb;
      c_blink  = blink;
      c_cursor = cursor_here;
    end

    pix_next = c_bg;
    if (c_cnt != '0) begin
      if (c_cursor && cursor_phase)
        pix_next = c_fg;
      else if (c_blink && char_phase)
        pix_next = c_bg;
      else
        pix_next = c_sr[CELL_W-1] ? c_fg : c_bg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      fg_q      <= RGB_BLACK;
      bg_q      <= RGB_BLACK;
      blink_q   <= 1'b0;
      cursor_q  <= 1'b0;
      pix_rgb   <= RGB_BLACK;
      pix_valid <= 1'b0;
    end else begin
      fg_q     <= c_fg;
      bg_q     <= c_bg;
      blink_q  <= c_blink;
      cursor_q <= c_cursor;
      // Shift even while blanked so cell alignment survives active gaps.
      if (c_cnt != '0) begin
        sr  <= c_sr << 1;
        cnt <= c_cnt - PIXCNT_W'(1);
      end
      pix_rgb   <= active ? pix_next : RGB_BLACK;
      pix_valid <= active;
    end
  end
endmodule
